hdmi_scanout_ctrl: RTL and testbench

Scanout controller for the 784-byte (28×28, 8-bit grey) HDMI frame memory. It generates 640×480@60 video timing and fetches image bytes to show the image upscaled in a fixed window. It also arbitrates the single memory port between those fetches and byte writes forwarded from the APB slave. It sits between the APB-side write path and the HDMI/TMDS encoder.

---
 rtl/hdmi_pkg.sv | 37 +++
 rtl/hdmi_timing_gen.sv | 51 +++++
 rtl/hdmi_scanout_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hdmi_scanout_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared timing constants, image defaults and types for the HDMI scanout controller.
package hdmi_pkg;
  typedef logic [9:0] cnt_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t H_ACT_END  = cnt_t'(H_ACTIVE);
  localparam cnt_t H_SYNC_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_ACT_END  = cnt_t'(V_ACTIVE);
  localparam cnt_t V_SYNC_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int ADDR_W    = 10;

  localparam logic [7:0] GREY_BG     = 8'h00;
  localparam logic [7:0] GREY_BORDER = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WRITE} mem_op_e;

  function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction
endpackage

// File: rtl/hdmi_timing_gen.sv
// 640x480@60 counters with raw sync/de/frame_start; en=0 holds counters at 0 and idles the raw outputs.
module hdmi_timing_gen
  import hdmi_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic [9:0] o_hcnt,
  output logic [9:0] o_vcnt,
  output logic [9:0] o_hcnt_nxt,
  output logic [9:0] o_vcnt_nxt,
  output logic       o_hsync_raw,
  output logic       o_vsync_raw,
  output logic       o_de_raw,
  output logic       o_fs_raw
);
  cnt_t r_hcnt, r_vcnt;
  cnt_t w_hcnt_nxt, w_vcnt_nxt;

  always_comb begin
    w_hcnt_nxt = '0;
    w_vcnt_nxt = '0;
    if (i_en) begin
      if (r_hcnt == H_LAST) begin
        w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + cnt_t'(1);
      end else begin
        w_hcnt_nxt = r_hcnt + cnt_t'(1);
        w_vcnt_nxt = r_vcnt;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
    end
  end

  assign o_hcnt      = r_hcnt;
  assign o_vcnt      = r_vcnt;
  assign o_hcnt_nxt  = w_hcnt_nxt;
  assign o_vcnt_nxt  = w_vcnt_nxt;
  assign o_hsync_raw = !(i_en && in_range(r_hcnt, H_SYNC_BEG, H_SYNC_END));
  assign o_vsync_raw = !(i_en && in_range(r_vcnt, V_SYNC_BEG, V_SYNC_END));
  assign o_de_raw    = i_en && (r_hcnt < H_ACT_END) && (r_vcnt < V_ACT_END);
  assign o_fs_raw    = i_en && (r_hcnt == '0) && (r_vcnt == '0);
endmodule

// File: rtl/hdmi_scanout_ctrl.sv
// HDMI scanout: upscaled image window fetch, memory port arbitration with APB writes, 2-cycle video pipe.
// Optional 1-pixel 0xFF frame around the window when HDMI_SCANOUT_BORDER_EN is defined.
module hdmi_scanout_ctrl
  import hdmi_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int SCALE = 8,
  parameter int X0    = 208,
  parameter int Y0    = 128
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              en,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [7:0]        pixel,
  output logic              frame_start
);
  localparam cnt_t X_BEG  = cnt_t'(X0);
  localparam cnt_t X_END  = cnt_t'(X0 + IMG_W * SCALE);
  localparam cnt_t Y_BEG  = cnt_t'(Y0);
  localparam cnt_t Y_END  = cnt_t'(Y0 + IMG_H * SCALE);
  localparam cnt_t S_LAST = cnt_t'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] IMG_BYTES = ADDR_W'(IMG_W * IMG_H);

  cnt_t w_hcnt, w_vcnt, w_hcnt_nxt, w_vcnt_nxt;
  logic w_hs_raw, w_vs_raw, w_de_raw, w_fs_raw;

  hdmi_timing_gen u_timing (
    .i_clk       (PCLK),
    .i_rst       (PRESET),
    .i_en        (en),
    .o_hcnt      (w_hcnt),
    .o_vcnt      (w_vcnt),
    .o_hcnt_nxt  (w_hcnt_nxt),
    .o_vcnt_nxt  (w_vcnt_nxt),
    .o_hsync_raw (w_hs_raw),
    .o_vsync_raw (w_vs_raw),
    .o_de_raw    (w_de_raw),
    .o_fs_raw    (w_fs_raw)
  );

  // Fetches are planned from next-cycle counters so mem_addr is on the bus during the fetch cycle itself.
  cnt_t              r_xsub, r_ysub, w_xsub_nxt;
  logic [ADDR_W-1:0] r_col, r_row_base;
  logic              w_fetch_nxt, w_vwin_cur, w_win_cur, w_bord_cur;
  mem_op_e           r_state, w_state_nxt;

  always_comb begin
    w_xsub_nxt = r_xsub + cnt_t'(1);
    if (w_hcnt_nxt == X_BEG || r_xsub == S_LAST) w_xsub_nxt = '0;
  end

  assign w_fetch_nxt = in_range(w_hcnt_nxt, X_BEG, X_END) && in_range(w_vcnt_nxt, Y_BEG, Y_END)
                       && (w_xsub_nxt == '0);
  assign w_vwin_cur  = in_range(w_vcnt, Y_BEG, Y_END);
  assign w_win_cur   = en && w_vwin_cur && in_range(w_hcnt, X_BEG, X_END);

`ifdef HDMI_SCANOUT_BORDER_EN
  localparam cnt_t X_PRE  = cnt_t'(X0 - 1);
  localparam cnt_t X_POST = cnt_t'(X0 + IMG_W * SCALE + 1);
  localparam cnt_t Y_PRE  = cnt_t'(Y0 - 1);
  localparam cnt_t Y_POST = cnt_t'(Y0 + IMG_H * SCALE + 1);
  assign w_bord_cur = en && (
      ((w_hcnt == X_PRE || w_hcnt == X_END) && in_range(w_vcnt, Y_PRE, Y_POST)) ||
      ((w_vcnt == Y_PRE || w_vcnt == Y_END) && in_range(w_hcnt, X_PRE, X_POST)));
`else
  assign w_bord_cur = 1'b0;
`endif

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_fetch_nxt)                          w_state_nxt = ST_FETCH;
    else if (wr_req && r_state != ST_WRITE)   w_state_nxt = ST_WRITE;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_xsub     <= '0;
      r_ysub     <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else begin
      r_xsub <= w_xsub_nxt;
      if (w_hcnt_nxt == '0) begin
        r_col <= '0;
        if (w_vcnt_nxt == '0) begin
          r_row_base <= '0;
          r_ysub     <= '0;
        end else if (w_vwin_cur) begin
          if (r_ysub == S_LAST) begin
            r_ysub     <= '0;
            r_row_base <= r_row_base + ROW_STEP;
          end else begin
            r_ysub <= r_ysub + cnt_t'(1);
          end
        end
      end else if (w_fetch_nxt) begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_mem_we, r_wr_ack;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_wr_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= 1'b0;
      r_wr_ack <= 1'b0;
      case (w_state_nxt)
        ST_FETCH: r_mem_addr <= r_row_base + r_col;
        ST_WRITE: begin
          r_mem_addr  <= wr_addr;
          r_mem_wdata <= wr_data;
          r_mem_we    <= (wr_addr < IMG_BYTES);
          r_wr_ack    <= 1'b1;
        end
        default: begin end
      endcase
    end
  end

  // Stage 1 captures counter-cycle decode; stage 2 meets mem_rdata, one cycle after the fetch address.
  logic       r_hs1, r_vs1, r_de1, r_fs1, r_win1, r_bord1, r_rd_vld;
  logic [7:0] r_byte, w_byte;
  logic       r_hsync, r_vsync, r_de, r_fs;
  logic [7:0] r_pixel;

  assign w_byte = r_rd_vld ? mem_rdata : r_byte;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      {r_hs1, r_vs1, r_de1, r_fs1, r_win1, r_bord1, r_rd_vld} <= 7'b1100000;
      r_byte  <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_pixel <= '0;
    end else begin
      r_hs1    <= w_hs_raw;
      r_vs1    <= w_vs_raw;
      r_de1    <= w_de_raw;
      r_fs1    <= w_fs_raw;
      r_win1   <= w_win_cur;
      r_bord1  <= w_bord_cur;
      r_rd_vld <= (r_state == ST_FETCH);
      r_byte   <= w_byte;
      r_hsync  <= r_hs1;
      r_vsync  <= r_vs1;
      r_de     <= r_de1;
      r_fs     <= r_fs1;
      r_pixel  <= !r_de1 ? 8'h00 : r_win1 ? w_byte : r_bord1 ? GREY_BORDER : GREY_BG;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign wr_ack      = r_wr_ack;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign pixel       = r_pixel;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_hdmi_scanout_ctrl.sv
// Bench for hdmi_scanout_ctrl with a short window (Y0=4, SCALE=2) so the whole image scans in a few lines.
`timescale 1ns/1ps
module tb_hdmi_scanout_ctrl;
  localparam int X0 = 208, Y0 = 4, SCALE = 2, IMG_W = 28, IMG_H = 28;
`ifdef HDMI_SCANOUT_BORDER_EN
  localparam logic [7:0] BORD = 8'hFF;
`else
  localparam logic [7:0] BORD = 8'h00;
`endif

  logic       PCLK = 1'b0, PRESET = 1'b1, en = 1'b0, wr_req = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ack, mem_we, hsync, vsync, de, frame_start;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata, pixel;
  logic [7:0] mem [0:1023];

  int checks = 0, failures = 0, idx = 0;

  hdmi_scanout_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .X0(X0), .Y0(Y0)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .en(en), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hsync(hsync), .vsync(vsync),
    .de(de), .pixel(pixel), .frame_start(frame_start)
  );

  always #5 PCLK = ~PCLK;

  // Synchronous RAM: preloaded with address mod 256 during reset, read data one cycle after address.
  always @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int         line;
    int         hpos;
    logic [7:0] pix;
    logic       de;
    logic       hs;
    logic       vs;
  } vec_t;
  vec_t vt[$];

  task automatic add(input int l, input int h, input logic [7:0] p, input logic d,
                     input logic hs, input logic vs);
    vec_t v;
    v.line = l; v.hpos = h; v.pix = p; v.de = d; v.hs = hs; v.vs = vs;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // idx equals the counter cycle whose memory bus is visible; video for cycle t is sampled at idx t+2.
  task automatic wait_idx(input int target);
    if (idx > target) begin
      failures++;
      $display("FAIL schedule: at %0d already past %0d", idx, target);
    end
    while (idx < target) begin
      @(negedge PCLK);
      idx++;
    end
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      wait_idx(vt[i].line * 800 + vt[i].hpos + 2);
      chk($sformatf("pixel l%0d h%0d", vt[i].line, vt[i].hpos), pixel, vt[i].pix);
      chk($sformatf("de l%0d h%0d", vt[i].line, vt[i].hpos), de, vt[i].de);
      chk($sformatf("hsync l%0d h%0d", vt[i].line, vt[i].hpos), hsync, vt[i].hs);
      chk($sformatf("vsync l%0d h%0d", vt[i].line, vt[i].hpos), vsync, vt[i].vs);
    end
  endtask

  int na, f, d, r;

  initial begin
    add(0, 639, 8'h00, 1, 1, 1);
    add(0, 640, 8'h00, 0, 1, 1);
    add(0, 655, 8'h00, 0, 1, 1);
    add(0, 656, 8'h00, 0, 0, 1);
    add(0, 751, 8'h00, 0, 0, 1);
    add(0, 752, 8'h00, 0, 1, 1);
    add(1, 655, 8'h00, 0, 1, 1);
    add(1, 656, 8'h00, 0, 0, 1);
    add(Y0 - 1, X0, BORD, 1, 1, 1);
    add(Y0, X0 - 1, BORD, 1, 1, 1);
    add(Y0, X0, 8'h00, 1, 1, 1);
    add(Y0, X0 + 1, 8'h00, 1, 1, 1);
    add(Y0, X0 + 2, 8'h01, 1, 1, 1);
    add(Y0, X0 + 10, 8'h05, 1, 1, 1);
    add(Y0, X0 + 56, BORD, 1, 1, 1);
    na = vt.size();
    add(Y0 + 1, X0 + 8, 8'h04, 1, 1, 1);
    add(Y0 + 1, X0 + 10, 8'hA5, 1, 1, 1);
    add(Y0 + 2, X0, 8'h1C, 1, 1, 1);
    add(Y0 + 2, X0 + 2, 8'h1D, 1, 1, 1);
    add(Y0 + 55, X0 + 54, 8'h0F, 1, 1, 1);
    add(Y0 + 55, X0 + 55, 8'h0F, 1, 1, 1);
    add(Y0 + 55, X0 + 56, BORD, 1, 1, 1);
    add(Y0 + 56, X0, BORD, 1, 1, 1);
    add(Y0 + 57, X0, 8'h00, 1, 1, 1);

    repeat (3) @(negedge PCLK);
    chk("rst hsync", hsync, 1);
    chk("rst vsync", vsync, 1);
    chk("rst de", de, 0);
    chk("rst pixel", pixel, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst wr_ack", wr_ack, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    PRESET = 1'b0;
    repeat (4) @(negedge PCLK);
    chk("idle de", de, 0);
    chk("idle frame_start", frame_start, 0);
    chk("idle hsync", hsync, 1);

    @(negedge PCLK);
    en  = 1'b1;
    idx = 0;
    wait_idx(1); chk("fs at +1", frame_start, 0);
    wait_idx(2); chk("fs at +2", frame_start, 1);
    wait_idx(3); chk("fs at +3", frame_start, 0);

    // Out-of-range write: acknowledged but never strobed into memory.
    wait_idx(100);
    wr_addr = 10'd800; wr_data = 8'h77; wr_req = 1'b1;
    chk("oor ack early", wr_ack, 0);
    wait_idx(101);
    chk("oor ack", wr_ack, 1);
    chk("oor we", mem_we, 0);
    wr_req = 1'b0;
    wait_idx(102);
    chk("oor ack pulse", wr_ack, 0);
    chk("oor we after", mem_we, 0);

    apply(0, na);

    // Write raised in the col-0 fetch cycle of window line Y0+1; col 5 of this very line shows it.
    f = (Y0 + 1) * 800 + X0;
    wait_idx(f);
    chk("fetch addr col0", mem_addr, 0);
    chk("fetch we", mem_we, 0);
    wr_addr = 10'd5; wr_data = 8'hA5; wr_req = 1'b1;
    chk("wr ack in fetch", wr_ack, 0);
    wait_idx(f + 1);
    chk("wr ack", wr_ack, 1);
    chk("wr we", mem_we, 1);
    chk("wr addr", mem_addr, 5);
    chk("wr data", mem_wdata, 8'hA5);
    wr_req = 1'b0;
    wait_idx(f + 2);
    chk("wr ack single", wr_ack, 0);
    chk("wr we single", mem_we, 0);
    chk("fetch addr col1", mem_addr, 1);

    apply(na, vt.size());

    // Drop en in the middle of an hsync pulse.
    d = 62 * 800 + 700;
    wait_idx(d);
    en = 1'b0;
    wait_idx(d + 1);
    chk("drop hsync prev", hsync, 0);
    wait_idx(d + 2);
    chk("drop hsync", hsync, 1);
    chk("drop vsync", vsync, 1);
    chk("drop de", de, 0);
    chk("drop pixel", pixel, 0);
    chk("drop frame_start", frame_start, 0);
    chk("drop wr_ack", wr_ack, 0);
    chk("drop mem_we", mem_we, 0);
    wait_idx(d + 3);
    wr_addr = 10'd10; wr_data = 8'h3C; wr_req = 1'b1;
    wait_idx(d + 4);
    chk("off wr ack", wr_ack, 1);
    chk("off wr we", mem_we, 1);
    chk("off wr addr", mem_addr, 10);
    chk("off wr data", mem_wdata, 8'h3C);
    wr_req = 1'b0;
    wait_idx(d + 5);
    chk("off wr ack pulse", wr_ack, 0);
    wait_idx(d + 10);
    chk("off de", de, 0);
    chk("off frame_start", frame_start, 0);
    chk("off hsync", hsync, 1);

    // Restart: fresh frame from 0,0 carrying both earlier writes.
    r = d + 20;
    wait_idx(r);
    en = 1'b1;
    wait_idx(r + 1); chk("restart fs +1", frame_start, 0);
    wait_idx(r + 2); chk("restart fs +2", frame_start, 1);
    wait_idx(r + 3); chk("restart fs +3", frame_start, 0);
    wait_idx(r + Y0 * 800 + X0 + 2);
    chk("restart col0", pixel, 8'h00);
    wait_idx(r + Y0 * 800 + X0 + 10 + 2);
    chk("restart col5", pixel, 8'hA5);
    wait_idx(r + Y0 * 800 + X0 + 20 + 2);
    chk("restart col10", pixel, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
